// File: rtl/signal_in_sync_multi.sv
// Multi-channel input conditioner: per-channel synchroniser, optional glitch filter
// (enabled by defining SIGNAL_SYNC_FILTER_EN), rise/fall pulses and an activity window.
module signal_in_sync_multi #(
  parameter int CHANNELS    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int IDLE_CYCLES = 50_000_000
) (
  input  logic                clk_50M,
  input  logic                rst,
  input  logic [CHANNELS-1:0] signal_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] active
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("CHANNELS out of range 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("SYNC_STAGES out of range 2..4");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 16) begin : g_bad_filter
    $error("FILTER_LEN out of range 1..16");
  end
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 67108863) begin : g_bad_idle
    $error("IDLE_CYCLES out of range 1..2^26-1");
  end

  localparam logic [25:0] IDLE_LOAD = 26'(IDLE_CYCLES);
`ifdef SIGNAL_SYNC_FILTER_EN
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] s;
    logic                   sync_q;
    logic                   accept;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   active_q;
    logic [25:0]            icnt;
    logic [25:0]            icnt_next;

    // Only s[0] touches the asynchronous pin.
    always_ff @(posedge clk_50M) begin
      if (rst) s <= '0;
      else     s <= {s[SYNC_STAGES-2:0], signal_in[i]};
    end

    assign sync_q = s[SYNC_STAGES-1];

`ifdef SIGNAL_SYNC_FILTER_EN
    logic [FW-1:0] fcnt;

    // fcnt counts consecutive samples that disagree with the accepted level.
    assign accept = (sync_q != level_q) && (fcnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge clk_50M) begin
      if (rst)                            fcnt <= '0;
      else if (sync_q == level_q || accept) fcnt <= '0;
      else                                fcnt <= fcnt + 1'b1;
    end
`else
    assign accept = (sync_q != level_q);
`endif

    always_comb begin
      icnt_next = icnt;
      if (accept)           icnt_next = IDLE_LOAD;
      else if (icnt != '0)  icnt_next = icnt - 26'd1;
    end

    // active follows the next counter state so it rises with the edge pulse.
    always_ff @(posedge clk_50M) begin
      if (rst) begin
        level_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        icnt     <= '0;
        active_q <= 1'b0;
      end else begin
        if (accept) level_q <= sync_q;
        rise_q   <= accept & sync_q;
        fall_q   <= accept & ~sync_q;
        icnt     <= icnt_next;
        active_q <= (icnt_next != '0);
      end
    end

    assign level_out[i]  = level_q;
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
    assign active[i]     = active_q;
  end

endmodule

// File: tb/tb_signal_in_sync_multi.sv
// Bench for signal_in_sync_multi: randomized and directed inputs, a lookback reference
// model feeding an expected queue, and a monitor comparing DUT outputs every cycle.
module tb_signal_in_sync_multi;
  localparam int CH    = 4;
  localparam int SS    = 2;
  localparam int FL    = 4;
  localparam int IDLE  = 10;
`ifdef SIGNAL_SYNC_FILTER_EN
  localparam int F = FL;
`else
  localparam int F = 1;
`endif
  localparam int W     = 4 * CH;
  localparam int MAXC  = 4096;

  logic          clk_50M = 1'b0;
  logic          rst;
  logic [CH-1:0] signal_in;
  logic [CH-1:0] level_out, rise_pulse, fall_pulse, active;

  signal_in_sync_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_LEN(FL), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk_50M(clk_50M), .rst(rst), .signal_in(signal_in),
    .level_out(level_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .active(active)
  );

  // clock / reset block
  always #10 clk_50M = ~clk_50M;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  // reference model: raw input history per edge, level accepted when the
  // synchronised value has disagreed with it for the last F edges
  logic [CH-1:0] hist [0:MAXC-1];
  logic [CH-1:0] m_level = '0;
  int            cyc = 0;
  int            last_rst = -1;
  int            last_acc [CH];
  bit            has_acc  [CH];
  int            m_rises  [CH];
  int            d_rises  [CH];

  function automatic logic [CH-1:0] sync_before(int e);
    if (e - SS < 0) return '0;
    return hist[e - SS];
  endfunction

  always @(posedge clk_50M) begin
    if (run && cyc < MAXC) begin
      logic [CH-1:0] r, f, a, sv;
      r = '0; f = '0; a = '0;
      if (rst) begin
        for (int k = 0; k < SS; k++) if (cyc - k >= 0) hist[cyc - k] = '0;
        m_level  = '0;
        last_rst = cyc;
        for (int c = 0; c < CH; c++) has_acc[c] = 1'b0;
      end else begin
        hist[cyc] = signal_in;
        for (int c = 0; c < CH; c++) begin
          bit acc;
          acc = 1'b1;
          for (int j = 0; j < F; j++) begin
            sv = sync_before(cyc - j);
            if (cyc - j <= last_rst || sv[c] == m_level[c]) acc = 1'b0;
          end
          if (acc) begin
            m_level[c]  = ~m_level[c];
            r[c]        = m_level[c];
            f[c]        = ~m_level[c];
            last_acc[c] = cyc;
            has_acc[c]  = 1'b1;
            if (m_level[c]) m_rises[c]++;
          end
          a[c] = has_acc[c] && (cyc - last_acc[c] < IDLE);
        end
      end
      exp_q.push_back({a, f, r, m_level});
    end
    cyc++;
  end

  // monitor: one comparison per cycle of all outputs
  always @(negedge clk_50M) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v, got_v;
      exp_v = exp_q.pop_front();
      got_v = {active, fall_pulse, rise_pulse, level_out};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL outputs t=%0t got {act,fall,rise,lvl}=%h expected %h", $time, got_v, exp_v);
      end
      for (int c = 0; c < CH; c++) if (rise_pulse[c] === 1'b1) d_rises[c]++;
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic pulse_ch(input int c, input int width, input int gap);
    signal_in[c] = 1'b1;
    wait_cyc(width);
    signal_in[c] = 1'b0;
    wait_cyc(gap);
  endtask

  initial begin
    int hold [CH];
    for (int c = 0; c < CH; c++) begin
      last_acc[c] = 0; has_acc[c] = 1'b0; m_rises[c] = 0; d_rises[c] = 0; hold[c] = 0;
    end
    rst       = 1'b1;
    signal_in = 4'b1010;
    run       = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(20);
    signal_in = '0;
    wait_cyc(20);
    // single step up and down on channel 0
    signal_in[0] = 1'b1;
    wait_cyc(20);
    signal_in[0] = 1'b0;
    wait_cyc(20);
    // short pulses on channel 1, widths 1..5
    for (int w = 1; w <= 5; w++) pulse_ch(1, w, 15);
    // two edges nine cycles apart to stretch the activity window
    pulse_ch(2, 9, 25);
    // reset while channel 3 is partway through the filter
    signal_in[3] = 1'b1;
    wait_cyc(SS + 2);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(20);
    signal_in[3] = 1'b0;
    wait_cyc(20);
    // random bursts per channel with occasional resets
    for (int n = 0; n < 800; n++) begin
      @(negedge clk_50M);
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          signal_in[c] = 1'($urandom_range(0, 1));
          hold[c]      = $urandom_range(1, 8);
        end else begin
          hold[c]--;
        end
      end
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    wait_cyc(30);
    run = 1'b0;
    wait_cyc(3);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (d_rises[c] != m_rises[c]) begin
        failures++;
        $display("FAIL rise_count ch%0d got %0d expected %0d", c, d_rises[c], m_rises[c]);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signal_in_sync_multi.md
# signal_in_sync_multi

Parametrised multi-channel input conditioner for the frequency meter front end. Each asynchronous input is synchronised into the `clk_50M` domain through a configurable flip-flop chain, optionally de-glitched, and reported as a clean level plus single-cycle rise and fall pulses. A per-channel activity flag reports whether the channel has toggled within a programmable window. The gate/count logic consumes these outputs directly in place of raw pins.

## Interface
Parameters:
- `CHANNELS`, 1: number of independent input channels; valid range 1..32.
- `SYNC_STAGES`, 2: synchroniser flip-flops per channel; valid range 2..4.
- `FILTER_LEN`, 4: consecutive stable samples required to accept a new level; valid range 1..16. Used only when the filter is compiled in.
- `IDLE_CYCLES`, 50_000_000: clock cycles without an accepted edge before `active` drops; valid range 1..2^26-1, default is 1 s at 50 MHz.

Ports:
- `clk_50M`  in  1  system clock, 50 MHz; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `signal_in`  in  CHANNELS  asynchronous raw inputs.
- `level_out`  out  CHANNELS  conditioned level, registered.
- `rise_pulse`  out  CHANNELS  one-cycle pulse on each accepted 0→1 change, registered.
- `fall_pulse`  out  CHANNELS  one-cycle pulse on each accepted 1→0 change, registered.
- `active`  out  CHANNELS  high while an accepted edge occurred within the last `IDLE_CYCLES` cycles.

## Operation
Channels are fully independent. There is no cross-channel logic.

- **Sync chain:**
  - `s[0] <= signal_in[i]`, `s[k] <= s[k-1]`.
  - `sync_q = s[SYNC_STAGES-1]`.
  - Only `s[0]` may sample the asynchronous pin.
- **Filter (macro defined):**
  - Per-channel counter `fcnt`, width `$clog2(FILTER_LEN)` (minimum 1 bit).
  - If `sync_q == level_out`: `fcnt <= 0`.
  - Else if `fcnt == FILTER_LEN-1`: accept. Set `level_out <= sync_q` and `fcnt <= 0`.
  - Else: `fcnt <= fcnt + 1`.
  - Any return of `sync_q` to the current level before acceptance clears `fcnt`, so the glitch is discarded.
  - `FILTER_LEN = 1` accepts on the first mismatching sample.
- **Edge pulses:**
  - `rise_pulse[i]` and `fall_pulse[i]` are asserted in the same cycle that `level_out[i]` takes its new value.
  - Each pulse lasts exactly one cycle.
  - Rise and fall are never asserted together on the same channel.
- **Activity:**
  - Per-channel down-counter `icnt`, 26 bits.
  - On an accepted edge: `icnt <= IDLE_CYCLES`.
  - Otherwise, if `icnt != 0`: `icnt <= icnt - 1`.
  - `active` is a registered copy of `icnt != 0` from the next state, so it rises in the same cycle as the pulse.
  - An edge accepted in the cycle `icnt` would reach 0 reloads the counter, and `active` stays high.
- **Reset (`rst` high at a clock edge):** `s`, `fcnt`, `icnt`, `level_out`, `rise_pulse`, `fall_pulse` and `active` all become 0.
- **Reset applied mid-operation** discards in-progress filter counts and pending edges.
- **Input already high when `rst` is released:** the channel produces a normal `rise_pulse` once it passes the chain and filter. This is intended: every channel starts from a known low level.

## Timing
- Define edge 0 as the first clock edge at which `s[0]` samples a new, stable input value.
- `level_out`, `rise_pulse`/`fall_pulse` and `active` update after edge `L = SYNC_STAGES + F - 1`, where `F = FILTER_LEN` with the filter compiled in and `F = 1` without it.
  - Default with filter: `L = 5`.
  - Without filter: `L = 2`.
- Rejection rule: a `sync_q` excursion lasting fewer than `F` cycles produces no output change.
- Maximum accepted toggle rate per channel: one change every `F` cycles.
- `active` falls exactly `IDLE_CYCLES` cycles after the last accepted edge.
- No combinational path from any input to any output.

## Configuration
- `SIGNAL_SYNC_FILTER_EN` defined:
  - The glitch filter and the `fcnt` registers are built.
  - `FILTER_LEN` is honoured.
- `SIGNAL_SYNC_FILTER_EN` undefined:
  - No `fcnt` logic is built.
  - `level_out <= sync_q` every cycle, so latency is `SYNC_STAGES + 0` after edge 0.
  - `FILTER_LEN` is ignored.
  - All other behaviour is unchanged.

## Test plan
- Reset check: `CHANNELS=4`, inputs at 4'b1010, `rst` high for 3 cycles → all outputs 0 during reset. After release, channels 1 and 3 each give `rise_pulse` at edge 5 (default parameters), and `active` = 4'b1010.
- Latency check: filter on, `SYNC_STAGES=2`, `FILTER_LEN=4`, input 0→1 sampled at edge 0 → `level_out` and `rise_pulse` high after edge 5; pulse lasts 1 cycle. Input 1→0 → `fall_pulse` after 5 edges.
- Glitch rejection: filter on, `FILTER_LEN=4`, high pulses of 1, 2 and 3 cycles → no pulses and `level_out` stays 0. A 4-cycle pulse → one rise and one fall, 4 cycles apart.
- Filter compiled out: same 0→1 step → `level_out` high after edge 2. A 1-cycle input pulse → one rise and one fall on consecutive cycles.
- Activity window: `IDLE_CYCLES=10`, single rise at cycle T → `active` high from T through T+9 and low at T+10. A second edge at T+9 keeps `active` high until T+19.
- Channel independence and reset mid-operation: 8 channels driven with distinct periods (10, 11, ..., 17 cycles) → each channel's pulse count matches its own stimulus. `rst` asserted while `fcnt=2` → no spurious pulse; counts restart from 0.
